// File: rtl/vx_operand_gather_if.sv
// vx_operand_gather_if
//   Groups the three handshakes of the operand gather stage:
//     in_*  : issued instruction (valid/ready, payload, warp index, rs indices)
//     gpr_* : single GPR read port, response arrives one cycle after request
//     out_* : gathered operands toward dispatch (valid/ready)
//   master : upstream/GPR/downstream side (drives requests, GPR data, out_ready)
//   slave  : the gather stage itself
interface vx_operand_gather_if #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int WIS_W       = 2,
    parameter int META_W      = 64
);
    logic                          in_valid;
    logic                          in_ready;
    logic [META_W-1:0]             in_meta;
    logic [WIS_W-1:0]              in_wis;
    logic [NR_BITS-1:0]            in_rs1;
    logic [NR_BITS-1:0]            in_rs2;
    logic [NR_BITS-1:0]            in_rs3;

    logic                          gpr_rd_valid;
    logic [WIS_W+NR_BITS-1:0]      gpr_rd_addr;
    logic [NUM_THREADS*XLEN-1:0]   gpr_rd_data;

    logic                          out_valid;
    logic                          out_ready;
    logic [META_W-1:0]             out_meta;
    logic [WIS_W-1:0]              out_wis;
    logic [NUM_THREADS*XLEN-1:0]   out_rs1_data;
    logic [NUM_THREADS*XLEN-1:0]   out_rs2_data;
    logic [NUM_THREADS*XLEN-1:0]   out_rs3_data;

    modport master (
        output in_valid, in_meta, in_wis, in_rs1, in_rs2, in_rs3,
        input  in_ready,
        input  gpr_rd_valid, gpr_rd_addr,
        output gpr_rd_data,
        input  out_valid, out_meta, out_wis, out_rs1_data, out_rs2_data, out_rs3_data,
        output out_ready
    );

    modport slave (
        input  in_valid, in_meta, in_wis, in_rs1, in_rs2, in_rs3,
        output in_ready,
        output gpr_rd_valid, gpr_rd_addr,
        input  gpr_rd_data,
        output out_valid, out_meta, out_wis, out_rs1_data, out_rs2_data, out_rs3_data,
        input  out_ready
    );
endinterface

// File: rtl/vx_operand_gather.sv
// vx_operand_gather
//   Accepts one issued instruction, reads its nonzero source registers one
//   per cycle through a single 1-cycle-latency GPR read port (rs1 > rs2 > rs3),
//   then holds metadata plus gathered operand vectors on the out handshake.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high
//     bus   : vx_operand_gather_if.slave (in_*, gpr_*, out_* handshakes)
module vx_operand_gather #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int WIS_W       = 2,
    parameter int META_W      = 64
) (
    input  logic               clk,
    input  logic               reset,
    vx_operand_gather_if.slave bus
);
    localparam int DW = NUM_THREADS * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_OUT} state_e;

    state_e              r_state, w_state_nxt;
    logic [META_W-1:0]   r_meta;
    logic [WIS_W-1:0]    r_wis;
    logic [NR_BITS-1:0]  r_rs   [3];
    logic [2:0]          r_pend;     // operands still to be requested
    logic [2:0]          r_tag;      // one-hot: operand whose response lands this cycle
    logic [DW-1:0]       r_opnd [3];

    logic [2:0]          w_pend_in;
    logic [2:0]          w_sel_oh;
    logic [NR_BITS-1:0]  w_sel_idx;
    logic                w_accept;
    logic                w_rd_valid;

    assign w_pend_in = {bus.in_rs3 != '0, bus.in_rs2 != '0, bus.in_rs1 != '0};
    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;

    // Lowest pending operand wins; later assignments take priority.
    always_comb begin
        w_sel_oh  = 3'b100;
        w_sel_idx = r_rs[2];
        if (r_pend[1]) begin
            w_sel_oh  = 3'b010;
            w_sel_idx = r_rs[1];
        end
        if (r_pend[0]) begin
            w_sel_oh  = 3'b001;
            w_sel_idx = r_rs[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        w_rd_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = (|w_pend_in) ? S_READ : S_OUT;
            end
            S_READ: begin
                w_rd_valid = 1'b1;
                if ((r_pend & ~w_sel_oh) == 3'b000) w_state_nxt = S_DRAIN;
            end
            // last response is captured here; nothing else to do
            S_DRAIN: w_state_nxt = S_OUT;
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.gpr_rd_valid = w_rd_valid;
    assign bus.gpr_rd_addr  = w_rd_valid ? {r_wis, w_sel_idx} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_wis  <= '0;
            r_pend <= '0;
            r_tag  <= '0;
            for (int k = 0; k < 3; k++) begin
                r_rs[k]   <= '0;
                r_opnd[k] <= '0;
            end
        end else begin
            r_tag <= w_rd_valid ? w_sel_oh : 3'b000;
            for (int k = 0; k < 3; k++) begin
                if (r_tag[k]) r_opnd[k] <= bus.gpr_rd_data;
            end
            if (w_accept) begin
                r_meta  <= bus.in_meta;
                r_wis   <= bus.in_wis;
                r_rs[0] <= bus.in_rs1;
                r_rs[1] <= bus.in_rs2;
                r_rs[2] <= bus.in_rs3;
                r_pend  <= w_pend_in;
                for (int k = 0; k < 3; k++) r_opnd[k] <= '0;
            end else if (w_rd_valid) begin
                r_pend <= r_pend & ~w_sel_oh;
            end
        end
    end

    assign bus.out_meta     = r_meta;
    assign bus.out_wis      = r_wis;
    assign bus.out_rs1_data = r_opnd[0];
    assign bus.out_rs2_data = r_opnd[1];
    assign bus.out_rs3_data = r_opnd[2];
endmodule
